game_menu_ctrl: RTL and testbench

GAME_MENU_CTRL -- requirements
Module: game_menu_ctrl

---
 rtl/game_menu_ctrl_if.sv | 24 ++
 rtl/game_menu_ctrl.sv | 139 +++++++++++++
 tb/tb_game_menu_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/game_menu_ctrl_if.sv
// Button/event inputs and timer/state outputs of the game menu controller.
// master drives the buttons and observes the outputs; slave is the controller.
interface game_menu_ctrl_if;
  logic       btn_start;
  logic       btn_pause;
  logic       player_dead;
  logic [3:0] timerdig2;
  logic [3:0] timerdig1;
  logic [3:0] timerdig0;
  logic [1:0] game_state;
  logic       menu_on;
  logic       game_start;
  logic       timer_done;

  modport master (
    output btn_start, btn_pause, player_dead,
    input  timerdig2, timerdig1, timerdig0, game_state, menu_on, game_start, timer_done
  );

  modport slave (
    input  btn_start, btn_pause, player_dead,
    output timerdig2, timerdig1, timerdig0, game_state, menu_on, game_start, timer_done
  );
endinterface

// File: rtl/game_menu_ctrl.sv
// Game menu/play/pause/over FSM with an M:SS BCD countdown driven by a
// one-second prescaler that only runs while playing.
module game_menu_ctrl #(
  parameter int TICK_DIV  = 25000000,
  parameter int START_MIN = 3
) (
  input logic              clk,
  input logic              reset,
  game_menu_ctrl_if.slave  bus
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [3:0]    SMIN  = 4'(START_MIN);

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [3:0]    d2, d1, d0, d2_n, d1_n, d0_n;
  logic [CW-1:0] presc, presc_n;
  logic          prev_start, prev_pause;
  logic          gs, gs_n, td, td_n, menu, menu_n;

  logic          start_edge, pause_edge, tick, at_one;
  logic [3:0]    dec2, dec1, dec0;

  assign start_edge = bus.btn_start & ~prev_start;
  assign pause_edge = bus.btn_pause & ~prev_pause;
  assign tick       = (presc == LAST);
  assign at_one     = (d2 == 4'd0) && (d1 == 4'd0) && (d0 == 4'd1);

  // BCD borrow chain for one-second decrement of M:SS
  always_comb begin
    dec0 = (d0 == 4'd0) ? 4'd9 : d0 - 4'd1;
    dec1 = d1;
    dec2 = d2;
    if (d0 == 4'd0) begin
      dec1 = (d1 == 4'd0) ? 4'd5 : d1 - 4'd1;
      if (d1 == 4'd0) dec2 = d2 - 4'd1;
    end
  end

  always_comb begin
    state_n = state;
    d2_n    = d2;
    d1_n    = d1;
    d0_n    = d0;
    presc_n = presc;
    gs_n    = 1'b0;
    td_n    = 1'b0;
    unique case (state)
      MENU: begin
        if (start_edge) begin
          state_n = PLAY;
          d2_n    = SMIN;
          d1_n    = '0;
          d0_n    = '0;
          presc_n = '0;
          gs_n    = 1'b1;
        end
      end
      PLAY: begin
        if (bus.player_dead) begin
          // a coincident final tick still lands on 0:00 and reports it
          state_n = OVER;
          if (tick && at_one) begin
            d2_n = '0;
            d1_n = '0;
            d0_n = '0;
            td_n = 1'b1;
          end
        end else if (pause_edge) begin
          state_n = PAUSE;
        end else begin
          presc_n = tick ? '0 : presc + ONE;
          if (tick) begin
            d2_n = dec2;
            d1_n = dec1;
            d0_n = dec0;
            if (at_one) begin
              state_n = OVER;
              td_n    = 1'b1;
            end
          end
        end
      end
      PAUSE: begin
        if (start_edge)      state_n = MENU;
        else if (pause_edge) state_n = PLAY;
      end
      OVER: begin
        if (start_edge) state_n = MENU;
      end
      default: state_n = MENU;
    endcase
    menu_n = (state_n == MENU);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= MENU;
      d2         <= SMIN;
      d1         <= '0;
      d0         <= '0;
      presc      <= '0;
      prev_start <= 1'b1;
      prev_pause <= 1'b1;
      gs         <= 1'b0;
      td         <= 1'b0;
      menu       <= 1'b1;
    end else begin
      state      <= state_n;
      d2         <= d2_n;
      d1         <= d1_n;
      d0         <= d0_n;
      presc      <= presc_n;
      prev_start <= bus.btn_start;
      prev_pause <= bus.btn_pause;
      gs         <= gs_n;
      td         <= td_n;
      menu       <= menu_n;
    end
  end

  assign bus.game_state = state;
  assign bus.timerdig2  = d2;
  assign bus.timerdig1  = d1;
  assign bus.timerdig0  = d0;
  assign bus.menu_on    = menu;
  assign bus.game_start = gs;
  assign bus.timer_done = td;

endmodule

// File: tb/tb_game_menu_ctrl.sv
// Scoreboard bench for game_menu_ctrl: every output change is matched against
// the next snapshot the stimulus queued, plus direct timing checks.
module tb_game_menu_ctrl;
  logic clk;
  logic reset;

  game_menu_ctrl_if bus ();

  game_menu_ctrl #(.TICK_DIV(4), .START_MIN(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [16:0] sb[$];
  logic [16:0] prev_obs;
  logic [16:0] exp_obs;
  logic        mon_en = 1'b0;
  logic [16:0] obs_now;
  logic [11:0] digits;

  assign obs_now = {bus.game_state, bus.timerdig2, bus.timerdig1, bus.timerdig0,
                    bus.menu_on, bus.game_start, bus.timer_done};
  assign digits  = {bus.timerdig2, bus.timerdig1, bus.timerdig0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // expected snapshot {state, M, S1, S0, menu_on, game_start, timer_done}
  function automatic logic [16:0] snap(input logic [1:0] st, input int secs,
                                       input logic gsv, input logic tdv);
    logic [3:0] m, t, s;
    m = 4'(secs / 60);
    t = 4'((secs % 60) / 10);
    s = 4'(secs % 10);
    return {st, m, t, s, (st == 2'd0), gsv, tdv};
  endfunction

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_obs = obs_now;
    end else if (obs_now !== prev_obs) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'(obs_now), 32'(prev_obs));
      end else begin
        exp_obs = sb.pop_front();
        check("sb", 32'(obs_now), 32'(exp_obs));
      end
      prev_obs = obs_now;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    sb.push_back(snap(2'd1, 180, 1'b1, 1'b0));
    sb.push_back(snap(2'd1, 180, 1'b0, 1'b0));
    bus.btn_start = 1'b1;
    cyc();
    bus.btn_start = 1'b0;
  endtask

  task automatic push_run(input int from_s, input int to_s);
    for (int s = from_s; s >= to_s; s--) sb.push_back(snap(2'd1, s, 1'b0, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b1;
    bus.btn_start   = 1'b0;
    bus.btn_pause   = 1'b0;
    bus.player_dead = 1'b0;
    repeat (3) cyc();
    check("rst_state", 32'(bus.game_state), 32'd0);
    check("rst_digits", 32'(digits), 32'h300);
    check("rst_menu_on", 32'(bus.menu_on), 32'd1);
    check("rst_game_start", 32'(bus.game_start), 32'd0);
    check("rst_timer_done", 32'(bus.timer_done), 32'd0);
    reset = 1'b0;
    repeat (2) cyc();
    mon_en = 1'b1;

    // full countdown from 3:00
    start_game();
    check("start_pulse", 32'(bus.game_start), 32'd1);
    check("start_state", 32'(bus.game_state), 32'd1);
    check("start_digits", 32'(digits), 32'h300);
    push_run(179, 1);
    sb.push_back(snap(2'd3, 0, 1'b0, 1'b1));
    sb.push_back(snap(2'd3, 0, 1'b0, 1'b0));
    for (int i = 1; i <= 720; i++) begin
      cyc();
      if (i == 1)   check("start_pulse_end", 32'(bus.game_start), 32'd0);
      if (i == 3)   check("pre_tick", 32'(digits), 32'h300);
      if (i == 4)   check("first_tick", 32'(digits), 32'h259);
      if (i == 244) check("min_borrow", 32'(digits), 32'h159);
      if (i == 484) check("min_borrow2", 32'(digits), 32'h059);
      if (i == 719) check("last_sec", 32'(digits), 32'h001);
      if (i == 720) begin
        check("done_pulse", 32'(bus.timer_done), 32'd1);
        check("done_state", 32'(bus.game_state), 32'd3);
      end
    end
    repeat (5) cyc();
    check("over_hold_digits", 32'(digits), 32'h000);
    check("over_hold_state", 32'(bus.game_state), 32'd3);
    check("over_done_low", 32'(bus.timer_done), 32'd0);

    // player_dead at 1:37
    sb.push_back(snap(2'd0, 0, 1'b0, 1'b0));
    bus.btn_start = 1'b1;
    cyc();
    bus.btn_start = 1'b0;
    check("over_to_menu", 32'(bus.game_state), 32'd0);
    cyc();
    start_game();
    push_run(179, 97);
    repeat (333) cyc();
    check("at_137", 32'(digits), 32'h137);
    sb.push_back(snap(2'd3, 97, 1'b0, 1'b0));
    bus.player_dead = 1'b1;
    cyc();
    bus.player_dead = 1'b0;
    check("dead_state", 32'(bus.game_state), 32'd3);
    check("dead_digits", 32'(digits), 32'h137);
    check("dead_no_done", 32'(bus.timer_done), 32'd0);
    bus.btn_pause = 1'b1;
    cyc();
    bus.btn_pause = 1'b0;
    repeat (10) cyc();
    check("dead_hold", 32'(digits), 32'h137);
    check("over_ignores_pause", 32'(bus.game_state), 32'd3);
    sb.push_back(snap(2'd0, 97, 1'b0, 1'b0));
    bus.btn_start = 1'b1;
    cyc();
    bus.btn_start = 1'b0;
    check("dead_to_menu", 32'(bus.game_state), 32'd0);
    cyc();

    // pause at prescaler count 2, resume
    start_game();
    check("replay_digits", 32'(digits), 32'h300);
    repeat (2) cyc();
    sb.push_back(snap(2'd2, 180, 1'b0, 1'b0));
    bus.btn_pause = 1'b1;
    cyc();
    bus.btn_pause = 1'b0;
    check("pause_state", 32'(bus.game_state), 32'd2);
    repeat (20) cyc();
    bus.player_dead = 1'b1;
    cyc();
    bus.player_dead = 1'b0;
    repeat (29) cyc();
    check("pause_frozen", 32'(digits), 32'h300);
    check("pause_ignores_dead", 32'(bus.game_state), 32'd2);
    sb.push_back(snap(2'd1, 180, 1'b0, 1'b0));
    sb.push_back(snap(2'd1, 179, 1'b0, 1'b0));
    bus.btn_pause = 1'b1;
    cyc();
    bus.btn_pause = 1'b0;
    check("resume_state", 32'(bus.game_state), 32'd1);
    cyc();
    check("resume_plus1", 32'(digits), 32'h300);
    cyc();
    check("resume_plus2", 32'(digits), 32'h259);

    // start+pause together in PAUSE -> MENU
    sb.push_back(snap(2'd2, 179, 1'b0, 1'b0));
    bus.btn_pause = 1'b1;
    cyc();
    bus.btn_pause = 1'b0;
    cyc();
    sb.push_back(snap(2'd0, 179, 1'b0, 1'b0));
    bus.btn_start = 1'b1;
    bus.btn_pause = 1'b1;
    cyc();
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;
    check("both_to_menu", 32'(bus.game_state), 32'd0);
    check("menu_on_again", 32'(bus.menu_on), 32'd1);
    cyc();
    bus.btn_pause   = 1'b1;
    bus.player_dead = 1'b1;
    cyc();
    bus.btn_pause   = 1'b0;
    bus.player_dead = 1'b0;
    repeat (2) cyc();
    check("menu_ignores_pause", 32'(bus.game_state), 32'd0);

    // btn_start held through reset release
    sb.push_back(snap(2'd0, 180, 1'b0, 1'b0));
    bus.btn_start = 1'b1;
    reset         = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (5) cyc();
    check("held_start_menu", 32'(bus.game_state), 32'd0);
    bus.btn_start = 1'b0;
    cyc();
    start_game();
    check("held_then_press", 32'(bus.game_state), 32'd1);

    // reset mid-play at 2:15
    push_run(179, 135);
    repeat (180) cyc();
    check("at_215", 32'(digits), 32'h215);
    repeat (2) cyc();
    sb.push_back(snap(2'd0, 180, 1'b0, 1'b0));
    reset = 1'b1;
    #1;
    check("abort_state", 32'(bus.game_state), 32'd0);
    check("abort_digits", 32'(digits), 32'h300);
    check("abort_menu_on", 32'(bus.menu_on), 32'd1);
    check("abort_presc", 32'(dut.presc), 32'd0);
    repeat (3) cyc();
    check("abort_no_start", 32'(bus.game_start), 32'd0);
    check("abort_no_done", 32'(bus.timer_done), 32'd0);
    reset = 1'b0;
    repeat (8) cyc();
    check("abort_stays_menu", 32'(bus.game_state), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
